array_word_packer: RTL and testbench
====================================

Name: array_word_packer

Overview:
Downstream consumer of the 16-entry byte array stage. Accepts the array's 8-bit read stream (one byte per cycle when qualified) and packs consecutive bytes into 32-bit words. Completed words are buffered in a small output FIFO and presented on a valid/ready interface to the bus-side logic. The upstream array has no backpressure, so on FIFO overflow the block drops the word and records the event.

Parameters:
DATA_W, 8, input byte width
LANES, 4, bytes per output word
FIFO_DEPTH, 4, output word FIFO entries (power of two, >=2)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data qualified this cycle
in_data  input  DATA_W  byte from array read port
in_last  input  1  with in_valid: this byte closes the current word (partial flush)
out_valid  output  1  FIFO non-empty; out_data/out_keep valid
out_ready  input  1  consumer accepts head word
out_data  output  DATA_W*LANES  packed word, first byte in bits [7:0]
out_keep  output  LANES  lane-valid mask for out_data
overflow  output  1  sticky: a word was dropped since reset
drop_count  output  8  words dropped, saturating at 255
fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at clock edge): lane index=0, partial word cleared, FIFO emptied; out_valid=0, out_data=0, out_keep=0, overflow=0, drop_count=0, fifo_level=0. Any partial word or buffered word is discarded; no flush.
- Packing: on in_valid, byte goes to lane = lane index (little-endian; lane k in bits [8k+7:8k]); keep bit k set.
- Word completes when in_valid and (lane index==LANES-1 or in_last). The completed word (including the current byte) is pushed into the FIFO in that cycle. The lane index returns to 0, the partial register is cleared, and unused lanes hold data=0 and keep=0.
- in_last on lane 0: single-byte word, out_keep=4'b0001.
- in_valid=0: no state change in packer; in_last is ignored.
- Latency: completed word is visible on out_data/out_valid the cycle after the completing byte is sampled (FIFO empty case).
- FIFO: out_valid = level!=0; out_data/out_keep show the head combinationally from storage. out_data=0 and out_keep=0 when empty. Pop when out_valid & out_ready.
- Full handling: push with FIFO full and no pop in the same cycle -> word dropped; overflow<=1; drop_count increments, saturating at 255. Push and pop in the same cycle while full -> both succeed, level unchanged, no drop.
- Simultaneous push and pop when empty: push succeeds only; no pop, since out_valid=0.
- Pointers wrap modulo FIFO_DEPTH; level updates +1 on push-only, -1 on pop-only, unchanged on both.
- out_ready asserted with out_valid=0 has no effect.
- Packer never stalls; in_data is consumed every valid cycle regardless of FIFO state.

Decomposition:
- Shared package array_pkg: DATA_W, LANES, WORD_W=DATA_W*LANES, FIFO_DEPTH, DROP_CNT_MAX=255, word_t and keep_t typedefs, shared with the array stage.
- One sub-module: word_fifo. Synchronous FIFO with push/pop/full/empty/level and data+keep payload, instantiated once. Packing logic, overflow flag and drop counter stay in the top level.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 on 4 consecutive valid cycles, out_ready=1 -> one cycle later out_data=0x44332211, out_keep=4'hF, out_valid for 1 cycle.
- Bytes 0xAA,0xBB with in_last on 0xBB -> out_data=0x0000BBAA, out_keep=4'b0011; the next byte 0xCC lands in lane 0.
- out_ready=0, 20 consecutive bytes -> 5 words; 4 stored (fifo_level=4), 1 dropped, overflow=1, drop_count=1. Drain -> words in order 0x..04030201 etc., out_valid falls after 4 pops.
- FIFO full with out_ready=1 held while a word completes -> push and pop same cycle; no drop, level stays 4.
- rst asserted after 2 bytes of a word -> next cycle all outputs 0, level 0. Following 4 bytes form a fresh word with no stale lanes.
- 300 dropped words with out_ready=0 -> drop_count saturates at 255, overflow stays 1 until rst.

Source files
------------

// File: rtl/array_pkg.sv
// Shared widths and payload types for the byte array stage and its word packer.
package array_pkg;
    localparam int DATA_W       = 8;
    localparam int LANES        = 4;
    localparam int WORD_W       = DATA_W * LANES;
    localparam int FIFO_DEPTH   = 4;
    localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1;
    localparam int DROP_CNT_MAX = 255;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LANES-1:0]  keep_t;
    typedef logic [LVL_W-1:0]  level_t;

    typedef struct packed {
        word_t data;
        keep_t keep;
    } fifo_entry_t;
endpackage

// File: rtl/array_word_packer_if.sv
// Byte input stream and packed word output stream of the word packer.
interface array_word_packer_if;
    import array_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    word_t             out_data;
    keep_t             out_keep;

    modport slave  (input  in_valid, in_data, in_last, out_ready,
                    output out_valid, out_data, out_keep);
    modport master (output in_valid, in_data, in_last, out_ready,
                    input  out_valid, out_data, out_keep);
endinterface

// File: rtl/word_fifo.sv
// Synchronous word+keep FIFO; head is shown combinationally and forced to zero when empty.
module word_fifo
    import array_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fifo_entry_t                wr_entry,
    input  logic                       pop,
    output fifo_entry_t                head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LW    = PTR_W + 1;

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // A push into a full FIFO is accepted only if the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/array_word_packer.sv
// Packs the array's byte read stream into little-endian words, buffers them and
// drops (and counts) words that arrive while the output FIFO is full.
module array_word_packer
    import array_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    array_word_packer_if.slave  bus,
    output logic                overflow,
    output logic [7:0]          drop_count,
    output level_t              fifo_level
);
    localparam int LANE_W = $clog2(LANES);

    logic [LANE_W-1:0] lane_idx;
    word_t             part_data;
    keep_t             part_keep;
    word_t             cur_data;
    keep_t             cur_keep;
    logic              complete;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;
    fifo_entry_t       head;

    // Current word with this cycle's byte merged in; this is what gets pushed on completion.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic hit;
        assign hit = bus.in_valid && (lane_idx == LANE_W'(k));
        assign cur_data[k*DATA_W +: DATA_W] = hit ? bus.in_data : part_data[k*DATA_W +: DATA_W];
        assign cur_keep[k] = part_keep[k] | hit;
    end

    assign complete = bus.in_valid && ((lane_idx == LANE_W'(LANES-1)) || bus.in_last);
    assign pop      = bus.out_valid && bus.out_ready;
    assign drop     = complete && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_idx  <= '0;
            part_data <= '0;
            part_keep <= '0;
        end else if (bus.in_valid) begin
            if (complete) begin
                lane_idx  <= '0;
                part_data <= '0;
                part_keep <= '0;
            end else begin
                lane_idx  <= lane_idx + 1'b1;
                part_data <= cur_data;
                part_keep <= cur_keep;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'(DROP_CNT_MAX)) drop_count <= drop_count + 1'b1;
        end
    end

    word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (complete),
        .wr_entry ('{data: cur_data, keep: cur_keep}),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

    assign bus.out_valid = !empty;
    assign bus.out_data  = head.data;
    assign bus.out_keep  = head.keep;
endmodule

// File: tb/tb_array_word_packer.sv
// Directed checks of packing, partial flush, FIFO full/drop handling and reset.
module tb_array_word_packer;
    import array_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   overflow;
    logic [7:0] drop_count;
    level_t fifo_level;
    int     total = 0;
    int     bad   = 0;

    array_word_packer_if bus ();

    array_word_packer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .overflow   (overflow),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_w;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        idle(); idle();
        rst = 1'b0;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", bus.out_data, 32'h0);
        check("rst_keep", 32'(bus.out_keep), 32'h0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);

        // full word, consumer ready
        bus.out_ready = 1'b1;
        idle();
        check("ready_idle_level", 32'(fifo_level), 32'd0);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        check("w1_not_yet", 32'(bus.out_valid), 32'd0);
        send(8'h44, 1'b0);
        check("w1_valid", 32'(bus.out_valid), 32'd1);
        check("w1_data", bus.out_data, 32'h44332211);
        check("w1_keep", 32'(bus.out_keep), 32'hF);
        idle();
        check("w1_popped", 32'(bus.out_valid), 32'd0);
        check("w1_level0", 32'(fifo_level), 32'd0);

        // partial flush via in_last, then single-byte word
        bus.out_ready = 1'b0;
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        check("p_data", bus.out_data, 32'h0000BBAA);
        check("p_keep", 32'(bus.out_keep), 32'h3);
        send(8'hCC, 1'b1);
        check("p_level2", 32'(fifo_level), 32'd2);
        bus.out_ready = 1'b1;
        idle();
        check("s_data", bus.out_data, 32'h000000CC);
        check("s_keep", 32'(bus.out_keep), 32'h1);
        idle();
        check("s_empty", 32'(bus.out_valid), 32'd0);

        // 20 bytes with no consumer: 4 stored, 1 dropped
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) send(8'(i), 1'b0);
        check("ov_level", 32'(fifo_level), 32'd4);
        check("ov_flag", 32'(overflow), 32'd1);
        check("ov_count", 32'(drop_count), 32'd1);
        bus.out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            exp_w = {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
            check($sformatf("drain_%0d", w), bus.out_data, exp_w);
            idle();
        end
        check("drain_empty", 32'(bus.out_valid), 32'd0);

        // full FIFO, push and pop in the same cycle
        bus.out_ready = 1'b0;
        for (int i = 8'h21; i <= 8'h33; i++) send(8'(i), 1'b0);
        check("pp_full", 32'(fifo_level), 32'd4);
        bus.out_ready = 1'b1;
        send(8'h34, 1'b0);
        check("pp_level", 32'(fifo_level), 32'd4);
        check("pp_nodrop", 32'(drop_count), 32'd1);
        check("pp_head", bus.out_data, 32'h28272625);
        bus.out_ready = 1'b0;

        // reset mid-word discards everything
        send(8'h51, 1'b0); send(8'h52, 1'b0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("mr_valid", 32'(bus.out_valid), 32'd0);
        check("mr_data", bus.out_data, 32'h0);
        check("mr_level", 32'(fifo_level), 32'd0);
        check("mr_ovf", 32'(overflow), 32'd0);
        check("mr_drop", 32'(drop_count), 32'd0);
        send(8'h61, 1'b0); send(8'h62, 1'b0);
        check("mr_partial", 32'(bus.out_valid), 32'd0);
        send(8'h63, 1'b0); send(8'h64, 1'b0);
        check("mr_word", bus.out_data, 32'h64636261);
        check("mr_keep", 32'(bus.out_keep), 32'hF);

        // drop counter saturation
        for (int i = 0; i < 3; i++) send(8'h70, 1'b1);
        check("sat_fill", 32'(fifo_level), 32'd4);
        check("sat_none", 32'(drop_count), 32'd0);
        for (int i = 0; i < 100; i++) send(8'h80, 1'b1);
        check("sat_100", 32'(drop_count), 32'd100);
        for (int i = 0; i < 200; i++) send(8'h81, 1'b1);
        check("sat_255", 32'(drop_count), 32'd255);
        check("sat_ovf", 32'(overflow), 32'd1);
        check("sat_head", bus.out_data, 32'h64636261);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("sat_rst_ovf", 32'(overflow), 32'd0);
        check("sat_rst_drop", 32'(drop_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
